// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if
//  Groups the two master request/response channels and the peripheral I/O bus
//  that io_bus_arbiter connects.
//  slave  modport: arbiter view (takes requests and io_dR, drives acks, rdata, strobes)
//  master modport: requester / peripheral side (drives requests and io_dR)
//  Signals:
//   m0_req/m0_isW/m0_addr/m0_wdata -> arbiter   m0_rdata/m0_ack <- arbiter
//   m1_req/m1_isW/m1_addr/m1_wdata -> arbiter   m1_rdata/m1_ack <- arbiter
//   io_isR/io_isW/io_addr/io_dW    <- arbiter   io_dR           -> arbiter
//  ADDR_W/DATA_W must match the parameters of the arbiter it is bound to.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_isW;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_isW;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic              io_isR;
    logic              io_isW;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_dW;
    logic [DATA_W-1:0] io_dR;

    modport slave (
        input  m0_req, m0_isW, m0_addr, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_req, m1_isW, m1_addr, m1_wdata,
        output m1_rdata, m1_ack,
        output io_isR, io_isW, io_addr, io_dW,
        input  io_dR
    );

    modport master (
        output m0_req, m0_isW, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_req, m1_isW, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack,
        input  io_isR, io_isW, io_addr, io_dW,
        output io_dR
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//  Shares the peripheral I/O bus between m0 (CPU load/store) and m1 (debug/loader).
//  Arbitrates in IDLE, registers the winning transaction, pulses a read or write
//  strobe for one cycle, waits RD_LAT cycles for read data and acks the owner.
//  Ports:
//   clk        system clock, rising edge
//   isReset_n  asynchronous active-low reset
//   bus        io_bus_arbiter_if.slave: master channels and peripheral bus
//   busy       high whenever the FSM is not IDLE
//   owner      master of the current/last transaction (0 = m0, 1 = m1)
//
//  state | meaning
//  IDLE  | arbitrate, latch winner's address/data/direction
//  ISSUE | one-cycle io_isR or io_isW strobe
//  WAIT  | counting down the read latency, sample io_dR at cnt == 0
//  ACK   | one-cycle ack to owner, then back to IDLE
module io_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            isReset_n,
    io_bus_arbiter_if.slave bus,
    output logic            busy,
    output logic            owner
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

    localparam logic [2:0] CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam logic [3:0] LIM      = 4'(STARVE_LIM);

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [3:0]        starve, starve_nxt;
    logic              is_wr, is_wr_nxt;
    logic              owner_nxt;
    logic              isr_q, isr_nxt, isw_q, isw_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] dw_q, dw_nxt;
    logic [DATA_W-1:0] rd0_q, rd0_nxt, rd1_q, rd1_nxt;
    logic              ack0_q, ack0_nxt, ack1_q, ack1_nxt;
    logic              pick_m1, grant, done, sample;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        starve_nxt = starve;
        is_wr_nxt  = is_wr;
        owner_nxt  = owner;
        addr_nxt   = addr_q;
        dw_nxt     = dw_q;
        rd0_nxt    = rd0_q;
        rd1_nxt    = rd1_q;
        isr_nxt    = 1'b0;
        isw_nxt    = 1'b0;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        done       = 1'b0;
        sample     = 1'b0;
        // m1 wins when alone, or when it has been passed over STARVE_LIM times in a row
        pick_m1    = bus.m1_req & (~bus.m0_req | (starve == LIM));
        grant      = pick_m1 | bus.m0_req;

        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ISSUE;
                    owner_nxt = pick_m1;
                    is_wr_nxt = pick_m1 ? bus.m1_isW  : bus.m0_isW;
                    addr_nxt  = pick_m1 ? bus.m1_addr : bus.m0_addr;
                    dw_nxt    = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                    isw_nxt   = is_wr_nxt;
                    isr_nxt   = ~is_wr_nxt;
                end
                // m1 requesting without winning implies m0 won over it
                if (!bus.m1_req || pick_m1)
                    starve_nxt = 4'd0;
                else if (starve < LIM)
                    starve_nxt = starve + 4'd1;
            end
            ISSUE: begin
                if (is_wr) begin
                    done = 1'b1;
                end else if (RD_LAT == 0) begin
                    sample = 1'b1;
                    done   = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    sample = 1'b1;
                    done   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            state_nxt = ACK;
            ack0_nxt  = ~owner;
            ack1_nxt  = owner;
        end
        if (sample) begin
            if (owner) rd1_nxt = bus.io_dR;
            else       rd0_nxt = bus.io_dR;
        end
    end

    always_ff @(posedge clk or negedge isReset_n) begin
        if (!isReset_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            starve <= 4'd0;
            is_wr  <= 1'b0;
            owner  <= 1'b0;
            isr_q  <= 1'b0;
            isw_q  <= 1'b0;
            addr_q <= '0;
            dw_q   <= '0;
            rd0_q  <= '0;
            rd1_q  <= '0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            starve <= starve_nxt;
            is_wr  <= is_wr_nxt;
            owner  <= owner_nxt;
            isr_q  <= isr_nxt;
            isw_q  <= isw_nxt;
            addr_q <= addr_nxt;
            dw_q   <= dw_nxt;
            rd0_q  <= rd0_nxt;
            rd1_q  <= rd1_nxt;
            ack0_q <= ack0_nxt;
            ack1_q <= ack1_nxt;
        end
    end

    assign busy         = (state != IDLE);
    assign bus.io_isR   = isr_q;
    assign bus.io_isW   = isw_q;
    assign bus.io_addr  = addr_q;
    assign bus.io_dW    = dw_q;
    assign bus.m0_ack   = ack0_q;
    assign bus.m1_ack   = ack1_q;
    assign bus.m0_rdata = rd0_q;
    assign bus.m1_rdata = rd1_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;
    localparam int RD_LAT_A = 1;
    localparam int RD_LAT_B = 2;

    logic clk;
    logic isReset_n;
    logic busy_a, owner_a, busy_b, owner_b;

    io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(16)) bus_a ();
    io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(16)) bus_b ();

    io_bus_arbiter #(.ADDR_W(32), .DATA_W(16), .RD_LAT(RD_LAT_A), .STARVE_LIM(4)) dut_a (
        .clk(clk), .isReset_n(isReset_n), .bus(bus_a.slave), .busy(busy_a), .owner(owner_a)
    );
    io_bus_arbiter #(.ADDR_W(32), .DATA_W(16), .RD_LAT(RD_LAT_B), .STARVE_LIM(4)) dut_b (
        .clk(clk), .isReset_n(isReset_n), .bus(bus_b.slave), .busy(busy_b), .owner(owner_b)
    );

    typedef struct {
        bit          m;
        bit          wr;
        logic [31:0] addr;
        logic [15:0] data;
        int          req_cyc;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] last_rd[2];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acks_seen = 0;
    int          acks_b = 0;
    bit          prev_strb = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_model(input logic [31:0] a);
        return a[15:0] ^ 16'hEE44;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DUT A monitor: strobes and acks are matched against the expected queue
    initial begin
        int          strobe_cyc;
        int          rd_due;
        logic [31:0] rd_addr;
        txn_t        t;
        strobe_cyc = -100;
        rd_due     = -1;
        rd_addr    = '0;
        bus_a.io_dR = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (!isReset_n) begin
                prev_strb = 0;
                rd_due    = -1;
            end else begin
                if (bus_a.io_isR || bus_a.io_isW) begin
                    chk("strobe_excl", 64'(bus_a.io_isR & bus_a.io_isW), 0);
                    chk("strobe_b2b", 64'(prev_strb), 0);
                    chk("busy_issue", 64'(busy_a), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        t = exp_q[0];
                        chk("strobe_dir", 64'(bus_a.io_isW), 64'(t.wr));
                        chk("io_addr", 64'(bus_a.io_addr), 64'(t.addr));
                        chk("owner_issue", 64'(owner_a), 64'(t.m));
                        if (t.wr) chk("io_dW", 64'(bus_a.io_dW), 64'(t.data));
                        if (t.req_cyc >= 0) chk("strobe_lat", 64'(cyc), 64'(t.req_cyc + 1));
                    end
                    strobe_cyc = cyc;
                    if (bus_a.io_isR) begin
                        rd_due  = cyc + RD_LAT_A;
                        rd_addr = bus_a.io_addr;
                    end
                end
                prev_strb = bus_a.io_isR | bus_a.io_isW;
                if (bus_a.m0_ack || bus_a.m1_ack) begin
                    chk("ack_excl", 64'(bus_a.m0_ack & bus_a.m1_ack), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 1, 0);
                    end else begin
                        t = exp_q.pop_front();
                        chk("ack_master", 64'(bus_a.m1_ack), 64'(t.m));
                        chk("ack_lat", 64'(cyc), 64'(strobe_cyc + (t.wr ? 1 : 1 + RD_LAT_A)));
                        chk("addr_hold", 64'(bus_a.io_addr), 64'(t.addr));
                        if (!t.wr) last_rd[t.m] = rd_model(t.addr);
                        chk(t.m ? "m1_rdata" : "m0_rdata",
                            64'(t.m ? bus_a.m1_rdata : bus_a.m0_rdata), 64'(last_rd[t.m]));
                    end
                    acks_seen++;
                end
            end
            // read data is only valid in the cycle the arbiter must sample it
            bus_a.io_dR = (cyc == rd_due) ? rd_model(rd_addr) : 16'hDEAD;
        end
    end

    // DUT B monitor: continuous m0 reads with io_dR changing every cycle
    initial begin
        int  s_cyc;
        int  last_ack;
        bit  prev_b;
        s_cyc    = -100;
        last_ack = -1;
        prev_b   = 0;
        bus_b.io_dR = 16'h0;
        forever begin
            @(negedge clk);
            if (!isReset_n) begin
                prev_b   = 0;
                last_ack = -1;
            end else begin
                if (bus_b.io_isR || bus_b.io_isW) begin
                    chk("b_b2b", 64'(prev_b), 0);
                    chk("b_dir", 64'(bus_b.io_isW), 0);
                    s_cyc = cyc;
                end
                prev_b = bus_b.io_isR | bus_b.io_isW;
                if (bus_b.m0_ack) begin
                    if (last_ack >= 0) chk("b_ack_period", 64'(cyc - last_ack), 5);
                    chk("b_ack_lat", 64'(cyc), 64'(s_cyc + 1 + RD_LAT_B));
                    chk("b_rdata", 64'(bus_b.m0_rdata), 64'(16'(s_cyc + RD_LAT_B) ^ 16'h3C00));
                    last_ack = cyc;
                    acks_b++;
                end
            end
            bus_b.io_dR = 16'(cyc) ^ 16'h3C00;
        end
    end

    task automatic wait_acks(input int n, input int budget);
        int target = acks_seen + n;
        int i = 0;
        while (acks_seen < target && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (acks_seen < target) chk("ack_timeout", 64'(acks_seen), 64'(target));
    endtask

    task automatic run_txn(input bit m, input bit wr, input logic [31:0] addr, input logic [15:0] data);
        txn_t t;
        @(negedge clk);
        #1;
        t.m = m; t.wr = wr; t.addr = addr; t.data = data; t.req_cyc = cyc;
        exp_q.push_back(t);
        if (m) begin
            bus_a.m1_isW = wr; bus_a.m1_addr = addr; bus_a.m1_wdata = data; bus_a.m1_req = 1'b1;
        end else begin
            bus_a.m0_isW = wr; bus_a.m0_addr = addr; bus_a.m0_wdata = data; bus_a.m0_req = 1'b1;
        end
        wait_acks(1, 20);
        bus_a.m0_req = 1'b0;
        bus_a.m1_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_isR"}, 64'(bus_a.io_isR), 0);
        chk({tag, "_isW"}, 64'(bus_a.io_isW), 0);
        chk({tag, "_addr"}, 64'(bus_a.io_addr), 0);
        chk({tag, "_dW"}, 64'(bus_a.io_dW), 0);
        chk({tag, "_acks"}, 64'({bus_a.m0_ack, bus_a.m1_ack}), 0);
        chk({tag, "_m0_rdata"}, 64'(bus_a.m0_rdata), 0);
        chk({tag, "_m1_rdata"}, 64'(bus_a.m1_rdata), 0);
        chk({tag, "_busy"}, 64'(busy_a), 0);
        chk({tag, "_owner"}, 64'(owner_a), 0);
    endtask

    initial begin
        int   k0, j1, guard, acks_before;
        bit   hit;
        txn_t t;
        bit   pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int   n0, n1;

        isReset_n = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        bus_a.m0_req = 0; bus_a.m0_isW = 0; bus_a.m0_addr = '0; bus_a.m0_wdata = '0;
        bus_a.m1_req = 0; bus_a.m1_isW = 0; bus_a.m1_addr = '0; bus_a.m1_wdata = '0;
        bus_b.m0_req = 0; bus_b.m0_isW = 0; bus_b.m0_addr = '0; bus_b.m0_wdata = '0;
        bus_b.m1_req = 0; bus_b.m1_isW = 0; bus_b.m1_addr = '0; bus_b.m1_wdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        chk("reset_b_busy", 64'(busy_b), 0);
        #1 isReset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single transactions on each master
        run_txn(0, 1, 32'hFFFF_FC60, 16'h00A5);
        run_txn(1, 0, 32'hFFFF_FC70, 16'h0000);
        chk("m1_rdata_1234", 64'(bus_a.m1_rdata), 64'h1234);
        run_txn(0, 0, 32'h0000_1111, 16'h0000);
        run_txn(1, 1, 32'h0000_0A0A, 16'hBEEF);
        run_txn(0, 1, 32'h0000_0004, 16'h7777);

        // both masters held high: grant order comes from the starvation table
        @(negedge clk);
        #1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            t.m = pat[i];
            t.req_cyc = (i == 0) ? cyc : -1;
            if (pat[i]) begin
                t.wr = 0; t.addr = 32'h3000 + 32'(4 * n1); t.data = '0; n1++;
            end else begin
                t.wr = 1; t.addr = 32'h2000 + 32'(4 * n0); t.data = 16'h0100 + 16'(n0); n0++;
            end
            exp_q.push_back(t);
        end
        k0 = 0; j1 = 0; guard = 0;
        bus_a.m0_isW = 1; bus_a.m0_addr = 32'h2000; bus_a.m0_wdata = 16'h0100;
        bus_a.m1_isW = 0; bus_a.m1_addr = 32'h3000;
        bus_a.m0_req = 1; bus_a.m1_req = 1;
        while ((k0 < 8 || j1 < 2) && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
            if (bus_a.m0_ack) begin
                k0++;
                if (k0 == 8) bus_a.m0_req = 0;
                else begin
                    bus_a.m0_addr  = 32'h2000 + 32'(4 * k0);
                    bus_a.m0_wdata = 16'h0100 + 16'(k0);
                end
            end
            if (bus_a.m1_ack) begin
                j1++;
                if (j1 == 2) bus_a.m1_req = 0;
                else bus_a.m1_addr = 32'h3000 + 32'(4 * j1);
            end
        end
        chk("starve_done", 64'({k0 == 8, j1 == 2}), 64'b11);
        chk("starve_queue_empty", 64'(exp_q.size()), 0);

        // reset in the middle of a read's WAIT cycle
        @(negedge clk);
        #1;
        t.m = 0; t.wr = 0; t.addr = 32'h0000_0040; t.data = '0; t.req_cyc = cyc;
        exp_q.push_back(t);
        bus_a.m0_isW = 0; bus_a.m0_addr = 32'h0000_0040; bus_a.m0_req = 1;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = bus_a.io_isR;
        end
        chk("mid_read_strobe_seen", 64'(hit), 1);
        @(posedge clk);
        #2 isReset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus_a.m0_req = 0;
        exp_q.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        acks_before = acks_seen;
        repeat (3) @(negedge clk);
        #1 isReset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("no_ack_after_reset", 64'(acks_seen), 64'(acks_before));
        chk("no_strobe_after_reset", 64'({bus_a.io_isR, bus_a.io_isW}), 0);
        run_txn(0, 1, 32'h0000_0050, 16'h5A5A);
        run_txn(0, 0, 32'h0000_0060, 16'h0000);

        // RD_LAT=2 instance: m0 holds its read request continuously
        @(negedge clk);
        #1;
        bus_b.m0_isW = 0; bus_b.m0_addr = 32'h0000_0070; bus_b.m0_req = 1;
        guard = 0;
        while (acks_b < 6 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        bus_b.m0_req = 0;
        chk("b_ack_count", 64'(acks_b), 6);
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
